// File: rtl/ycc_pixel_seq.sv
// ycc_pixel_seq: multi-cycle YCbCr-to-RGB custom instruction sharing one
// multiply/accumulate/clamp datapath across the R, G and B channels.
module ycc_pixel_seq #(
    parameter logic [7:0] ALPHA     = 8'h00,
    parameter int         FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, S_R, S_GA, S_GB, S_B, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [7:0]         y_q, y_d, r_q, r_d, g_q, g_d, ch;
    logic signed [8:0]  cb_q, cb_d, cr_q, cr_d, opnd;
    logic               fmt_q, fmt_d;
    logic signed [31:0] acc_q, acc_d, rnd, sum;
    logic signed [17:0] coef;
    logic signed [26:0] prod;
    logic [31:0]        result_q, result_d;
    logic               unused;

    assign unused = ^{dataa[31:24], datab[31:1]};

    function automatic logic [7:0] clamp8(input logic signed [31:0] s);
        return s < 0 ? 8'd0 : (s > 255 ? 8'd255 : s[7:0]);
    endfunction

    always_comb begin
        coef = state_q == S_R  ? 18'sd91881 :
               state_q == S_GA ? 18'sd22554 :
               state_q == S_GB ? 18'sd46802 : 18'sd116130;
        opnd = (state_q == S_R || state_q == S_GB) ? cr_q : cb_q;
        prod = 27'(coef) * 27'(opnd);
        // only the second half of G accumulates; every other step starts fresh
        acc_d = (state_q == S_GB ? acc_q : 32'sd0) + 32'(prod);
        rnd = (acc_d + (32'sd1 <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
        sum = state_q == S_GB ? $signed({24'd0, y_q}) - rnd : $signed({24'd0, y_q}) + rnd;
        ch = clamp8(sum);
        state_d = state_q;
        y_d = y_q;
        cb_d = cb_q;
        cr_d = cr_q;
        fmt_d = fmt_q;
        r_d = r_q;
        g_d = g_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = S_R;
                y_d = dataa[23:16];
                cb_d = $signed({1'b0, dataa[15:8]}) - 9'sd128;
                cr_d = $signed({1'b0, dataa[7:0]}) - 9'sd128;
                fmt_d = datab[0];
            end
            S_R: begin
                r_d = ch;
                state_d = S_GA;
            end
            S_GA: state_d = S_GB;
            S_GB: begin
                g_d = ch;
                state_d = S_B;
            end
            S_B: begin
                result_d = fmt_q ? {16'h0000, r_q[7:3], g_q[7:2], ch[7:3]} : {ALPHA, r_q, g_q, ch};
                state_d = S_OUT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            y_q <= '0;
            cb_q <= '0;
            cr_q <= '0;
            fmt_q <= 1'b0;
            r_q <= '0;
            g_q <= '0;
            acc_q <= '0;
            result_q <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            y_q <= y_d;
            cb_q <= cb_d;
            cr_q <= cr_d;
            fmt_q <= fmt_d;
            r_q <= r_d;
            g_q <= g_d;
            acc_q <= acc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign done = state_q == S_OUT;
    assign busy = state_q != IDLE;
endmodule
